// File: rtl/hex_display.sv
// hex_display
//   Registered hex-to-seven-segment decoder for one common-anode digit.
//   Segments are active-low: hex[0]=a ... hex[6]=g.
//
//   Optional feature macro: DISPLAY_BLINK_EN
//     Adds the `blink` input and a free-running blink-phase counter.
//     Without it the block behaves as if blink were tied low.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   en      in   load strobe for `number`
//   blank   in   force all segments off (registered)
//   blink   in   blink enable (DISPLAY_BLINK_EN builds only)
//   number  in   4-bit value to show
//   hex     out  7-bit active-low segment drive, straight from flops
module hex_display #(
    parameter int BLINK_PERIOD = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank,
`ifdef DISPLAY_BLINK_EN
    input  logic       blink,
`endif
    input  logic [3:0] number,
    output logic [6:0] hex
);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    generate
        if (BLINK_PERIOD < 1) begin : g_bad_period
            $error("hex_display: BLINK_PERIOD must be at least 1");
        end
    endgenerate

    logic [3:0] val;
    logic       blink_off;

    // X/Z on val matches no item and falls to default: all segments lit,
    // so an uninitialised datapath is obvious on the board.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] seg;
        seg = 7'b0000000;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val <= 4'h0;
        end else if (en) begin
            val <= number;
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int CW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_PERIOD - 1);

    logic [CW-1:0] blink_cnt;
    logic          blink_on;

    // Free-running so the blink cadence stays steady regardless of when
    // `blink` is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + CW'(1);
        end
    end

    assign blink_off = blink & ~blink_on;
`else
    assign blink_off = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex <= SEG_ZERO;
        end else if (blank) begin
            hex <= SEG_OFF;
        end else if (blink_off) begin
            hex <= SEG_OFF;
        end else begin
            hex <= decode(val);
        end
    end

endmodule

// File: tb/tb_hex_display.sv
module tb_hex_display;

    localparam int BP = 4;
    localparam logic [6:0] OFF  = 7'b1111111;
    localparam logic [6:0] ZERO = 7'b1000000;

    logic       clk;
    logic       rst;
    logic       en;
    logic       blank;
    logic [3:0] number;
    logic [6:0] hex;
`ifdef DISPLAY_BLINK_EN
    logic       blink;
`endif

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_tab [16];
    logic [6:0] exp_q [$];

    logic [3:0] m_val;
`ifdef DISPLAY_BLINK_EN
    int         m_cnt;
    logic       m_on;
`endif

    hex_display #(.BLINK_PERIOD(BP)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .blank  (blank),
`ifdef DISPLAY_BLINK_EN
        .blink  (blink),
`endif
        .number (number),
        .hex    (hex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: hex=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = 4'h0;
`ifdef DISPLAY_BLINK_EN
        m_cnt = 0;
        m_on  = 1'b1;
`endif
        exp_q.delete();
    endtask

    // Called just after a falling edge; drives inputs, predicts the hex value
    // registered at the coming rising edge, then compares after that edge.
    task automatic step(input logic e, input logic [3:0] n, input logic b, input string tag);
        logic [6:0] nxt;
        logic [6:0] got;
        en = e; number = n; blank = b;
        nxt = seg_tab[m_val];
`ifdef DISPLAY_BLINK_EN
        if (blink && !m_on) nxt = OFF;
`endif
        if (b) nxt = OFF;
        exp_q.push_back(nxt);
        if (e) m_val = n;
`ifdef DISPLAY_BLINK_EN
        if (m_cnt == BP - 1) begin
            m_cnt = 0;
            m_on  = !m_on;
        end else begin
            m_cnt++;
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s: scoreboard empty, hex=%b", tag, hex);
        end
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check(tag, hex, got);
        end
        @(negedge clk);
    endtask

    // Asserts reset between edges and expects hex to clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check(tag, hex, ZERO);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst = 1'b0; en = 1'b0; blank = 1'b0; number = 4'h0;
`ifdef DISPLAY_BLINK_EN
        blink = 1'b0;
`endif
        model_reset();

        // reset before any clock edge, then idle with en=0
        async_reset("reset_no_clk");
        step(1'b0, 4'h9, 1'b0, "idle0");
        step(1'b0, 4'h9, 1'b0, "idle1");

        // full sweep, one value per cycle, plus a flush cycle
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, "sweep");
        step(1'b0, 4'h0, 1'b0, "sweep_flush");

        // hold
        step(1'b1, 4'h7, 1'b0, "hold_load");
        step(1'b0, 4'h2, 1'b0, "hold0");
        step(1'b0, 4'h2, 1'b0, "hold1");
        check("hold_direct", hex, 7'b1111000);

        // blanking
        step(1'b1, 4'h8, 1'b0, "blank_load");
        step(1'b0, 4'h0, 1'b0, "blank_pre");
        step(1'b0, 4'h0, 1'b1, "blank_on");
        check("blank_direct", hex, OFF);
        step(1'b0, 4'h0, 1'b1, "blank_hold");
        step(1'b0, 4'h0, 1'b0, "blank_off");
        check("unblank_direct", hex, 7'b0000000);

        // simultaneous load and blank
        step(1'b1, 4'h5, 1'b1, "en_blank");
        step(1'b0, 4'h0, 1'b0, "en_blank_release");
        check("en_blank_direct", hex, 7'b0010010);

        // random back-to-back loads with occasional blank
        for (int i = 0; i < 24; i++)
            step(1'b1, 4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0), "random");
        step(1'b0, 4'h0, 1'b0, "random_flush");

        // async reset mid-stream
        step(1'b1, 4'hE, 1'b0, "midrst_load");
        step(1'b0, 4'h0, 1'b0, "midrst_show");
        check("midrst_shown", hex, 7'b0000110);
        async_reset("midrst_async");
        step(1'b0, 4'h3, 1'b0, "midrst_after");

`ifdef DISPLAY_BLINK_EN
        // blink: counter and phase restarted by the reset above
        blink = 1'b1;
        step(1'b1, 4'h1, 1'b0, "blink_load");
        for (int i = 0; i < 3 * BP; i++) step(1'b0, 4'h0, 1'b0, "blink_cycle");
        blink = 1'b0;
        for (int i = 0; i < 2 * BP; i++) step(1'b0, 4'h0, 1'b0, "blink_disabled");
        blink = 1'b1;
        step(1'b0, 4'h0, 1'b1, "blink_blank");
        for (int i = 0; i < BP; i++) step(1'b0, 4'h0, 1'b0, "blink_resume");
        blink = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
